// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_if #(parameter int DW = 32, parameter int CNTW = 16);
  logic stall, flush, id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_data1, id_data2, id_imm, id_pc4;
  logic [9:0] id_ctrl;
  logic wb_regwrite;
  logic [4:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic hazard, ex_valid;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_data1, ex_data2, ex_imm, ex_pc4;
  logic [9:0] ex_ctrl;
  logic [CNTW-1:0] bubble_cnt;
  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_data1, id_data2, id_imm, id_pc4, id_ctrl,
           wb_regwrite, wb_reg, wb_data,
    input  hazard, ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl, bubble_cnt
  );
  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_data1, id_data2, id_imm, id_pc4, id_ctrl,
           wb_regwrite, wb_reg, wb_data,
    output hazard, ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubble, stall, flush; BYPASS_WB_EN adds WB->ID data bypass.
module id_ex_reg #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst,
  id_ex_if.slave p
);
  logic [DW-1:0] d1, d2;
  logic bubble;
  assign p.hazard = !p.stall && p.ex_valid && p.ex_ctrl[8] && p.ex_rt != 5'd0 && p.id_valid &&
                    (p.ex_rt == p.id_rs || p.ex_rt == p.id_rt);
  // hazard is already gated by stall, so flush is the only bubble source that overrides a hold
  assign bubble = p.flush || p.hazard;
`ifdef BYPASS_WB_EN
  assign d1 = (p.wb_regwrite && p.wb_reg != 5'd0 && p.wb_reg == p.id_rs) ? p.wb_data : p.id_data1;
  assign d2 = (p.wb_regwrite && p.wb_reg != 5'd0 && p.wb_reg == p.id_rt) ? p.wb_data : p.id_data2;
`else
  logic unused_wb;
  assign unused_wb = ^{p.wb_regwrite, p.wb_reg, p.wb_data};
  assign d1 = p.id_data1;
  assign d2 = p.id_data2;
`endif
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      p.ex_valid <= 1'b0;
      p.ex_rs    <= '0;
      p.ex_rt    <= '0;
      p.ex_rd    <= '0;
      p.ex_data1 <= '0;
      p.ex_data2 <= '0;
      p.ex_imm   <= '0;
      p.ex_pc4   <= '0;
      p.ex_ctrl  <= '0;
    end else if (!p.stall) begin
      p.ex_valid <= p.id_valid;
      p.ex_rs    <= p.id_rs;
      p.ex_rt    <= p.id_rt;
      p.ex_rd    <= p.id_rd;
      p.ex_data1 <= d1;
      p.ex_data2 <= d2;
      p.ex_imm   <= p.id_imm;
      p.ex_pc4   <= p.id_pc4;
      p.ex_ctrl  <= p.id_valid ? p.id_ctrl : 10'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) p.bubble_cnt <= '0;
    else if (bubble && p.bubble_cnt != '1) p.bubble_cnt <= p.bubble_cnt + 1'b1;
  end
endmodule
